lap_time_ctl: RTL

LAP_TIME_CTL -- requirements
Module: lap_time_ctl

---
 rtl/racer_pkg.sv | 44 ++++
 rtl/bcd_time_counter.sv | 49 ++++
 rtl/lap_time_ctl.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/racer_pkg.sv
// Shared types and helpers for the lap timer.
// Time values are packed BCD MM:SS:FF, minutes in the most significant byte.
package racer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_COUNTDOWN = 2'd1,
        ST_RACING    = 2'd2,
        ST_FINISHED  = 2'd3
    } race_state_t;

    typedef logic [3:0]  bcd_digit_t;
    typedef logic [23:0] lap_time_t;

    // Bit offsets of the two-digit fields inside a lap_time_t
    localparam int FF_LSB = 0;
    localparam int SS_LSB = 8;
    localparam int MM_LSB = 16;

    // Increment a two-digit BCD value; caller guarantees it is below 99
    function automatic logic [7:0] bcd_inc2(input logic [7:0] v);
        bcd_digit_t hi;
        bcd_digit_t lo;
        hi = v[7:4];
        lo = v[3:0];
        if (lo == 4'd9) begin
            hi = hi + 4'd1;
            lo = 4'd0;
        end else begin
            lo = lo + 4'd1;
        end
        return {hi, lo};
    endfunction

    // Convert 0..99 to two BCD digits (used for elaboration constants)
    function automatic logic [7:0] to_bcd2(input int unsigned v);
        bcd_digit_t hi;
        bcd_digit_t lo;
        hi = 4'(v / 10);
        lo = 4'(v % 10);
        return {hi, lo};
    endfunction

endpackage

// File: rtl/bcd_time_counter.sv
// Cascaded BCD MM:SS:FF counter. FF wraps at FRAME_RATE-1, SS at 59, and the
// whole count saturates at 99:59:(FRAME_RATE-1). Clear has priority over tick.
module bcd_time_counter
    import racer_pkg::*;
#(
    parameter int FRAME_RATE = 60
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      clear,
    input  logic      tick,
    output lap_time_t value
);

    localparam logic [7:0] FF_MAX   = to_bcd2(unsigned'(FRAME_RATE - 1));
    localparam lap_time_t  MAX_TIME = {8'h99, 8'h59, FF_MAX};

    lap_time_t next_value;

    // Next count: ripple FF -> SS -> MM, hold once the ceiling is reached
    always_comb begin
        next_value = value;
        if (value != MAX_TIME) begin
            if (value[FF_LSB +: 8] == FF_MAX) begin
                next_value[FF_LSB +: 8] = 8'h00;
                if (value[SS_LSB +: 8] == 8'h59) begin
                    next_value[SS_LSB +: 8] = 8'h00;
                    next_value[MM_LSB +: 8] = bcd_inc2(value[MM_LSB +: 8]);
                end else begin
                    next_value[SS_LSB +: 8] = bcd_inc2(value[SS_LSB +: 8]);
                end
            end else begin
                next_value[FF_LSB +: 8] = bcd_inc2(value[FF_LSB +: 8]);
            end
        end
    end

    // Count register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= '0;
        end else if (clear) begin
            value <= '0;
        end else if (tick) begin
            value <= next_value;
        end
    end

endmodule

// File: rtl/lap_time_ctl.sv
// Race lap timer: countdown, per-lap BCD timing, last lap and optional best lap.
// Optional feature: define BEST_LAP_EN to build the best-lap register and
// comparator; otherwise best_time_bcd and best_valid are tied to 0.
// Handshake: all inputs are single-cycle pulses sampled on pclk; every output
// is a register updated on the pclk edge that samples the pulse.
module lap_time_ctl
    import racer_pkg::*;
#(
    parameter int NUM_LAPS    = 3,
    parameter int FRAME_RATE  = 60,
    parameter int COUNTDOWN_S = 3
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        frame_ended,
    input  logic        race_start,
    input  logic        race_abort,
    input  logic        lap_cross,
    output logic [23:0] cur_time_bcd,
    output logic [23:0] last_time_bcd,
    output logic [23:0] best_time_bcd,
    output logic        best_valid,
    output logic [3:0]  lap_count,
    output logic [3:0]  countdown,
    output logic        racing,
    output logic        race_done
);

    localparam logic [6:0] DIV_LAST   = 7'(FRAME_RATE - 1);
    localparam logic [3:0] CD_INIT    = 4'(COUNTDOWN_S);
    localparam logic [3:0] LAPS_TOTAL = 4'(NUM_LAPS);

    race_state_t state;
    logic [6:0]  frame_div;
    logic        start_ok;
    logic        lap_ok;
    logic        tick_run;
    logic        ctr_clear;

    // Qualified events: abort beats start, lap beats a coincident tick
    always_comb begin
        start_ok  = 1'b0;
        lap_ok    = 1'b0;
        tick_run  = 1'b0;
        ctr_clear = 1'b0;
        if (!race_abort) begin
            start_ok = race_start && (state == ST_IDLE || state == ST_FINISHED);
            lap_ok   = lap_cross && (state == ST_RACING);
            tick_run = frame_ended && (state == ST_RACING) && !lap_cross;
        end
        ctr_clear = race_abort || start_ok || lap_ok;
    end

    bcd_time_counter #(
        .FRAME_RATE (FRAME_RATE)
    ) u_counter (
        .clk   (pclk),
        .rst   (rst),
        .clear (ctr_clear),
        .tick  (tick_run),
        .value (cur_time_bcd)
    );

    // Race FSM with its registered status outputs
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            frame_div     <= '0;
            countdown     <= '0;
            lap_count     <= '0;
            last_time_bcd <= '0;
            racing        <= 1'b0;
            race_done     <= 1'b0;
        end else if (race_abort) begin
            state     <= ST_IDLE;
            frame_div <= '0;
            countdown <= '0;
            lap_count <= '0;
            racing    <= 1'b0;
            race_done <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_FINISHED: begin
                    if (race_start) begin
                        state         <= ST_COUNTDOWN;
                        frame_div     <= '0;
                        countdown     <= CD_INIT;
                        lap_count     <= '0;
                        last_time_bcd <= '0;
                        race_done     <= 1'b0;
                    end
                end
                ST_COUNTDOWN: begin
                    if (frame_ended) begin
                        if (frame_div == DIV_LAST) begin
                            frame_div <= '0;
                            if (countdown == 4'd1) begin
                                state     <= ST_RACING;
                                countdown <= '0;
                                racing    <= 1'b1;
                            end else begin
                                countdown <= countdown - 4'd1;
                            end
                        end else begin
                            frame_div <= frame_div + 7'd1;
                        end
                    end
                end
                ST_RACING: begin
                    if (lap_cross) begin
                        last_time_bcd <= cur_time_bcd;
                        lap_count     <= lap_count + 4'd1;
                        if (lap_count + 4'd1 == LAPS_TOTAL) begin
                            state     <= ST_FINISHED;
                            racing    <= 1'b0;
                            race_done <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef BEST_LAP_EN
    // Best lap: packed MSB-first BCD compares correctly as an unsigned number
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            best_time_bcd <= '0;
            best_valid    <= 1'b0;
        end else if (lap_ok && (!best_valid || cur_time_bcd < best_time_bcd)) begin
            best_time_bcd <= cur_time_bcd;
            best_valid    <= 1'b1;
        end
    end
`else
    assign best_time_bcd = '0;
    assign best_valid    = 1'b0;
`endif

endmodule
